// File: rtl/sensor_command_scheduler.sv
// Round-robin scheduler sharing one UART link: sends a 16-bit command as two bytes, returns a 2-byte reply.
// Latency: grant 1 cycle after req in IDLE; resp_valid 2 cycles after the last rx byte edge (1 cycle after a timeout).
// Backpressure: tx_start held off while tx_busy=1; every WAIT/RECV state aborts after TIMEOUT_CYCLES cycles.
//
// Ports:
//   clock, reset            - divided system clock, synchronous active-low reset
//   req, req_cmd            - per-requester level request and packed 16-bit command
//   grant                   - one-hot owner of the link for the whole transaction
//   resp_valid/data/error   - one-cycle reply pulse (data first byte in [15:8]; error = timeout)
//   tx_start, tx_byte       - UART transmitter handshake; tx_busy/tx_done from the transmitter
//   rx_valid, rx_byte       - UART receiver output
module sensor_command_scheduler #(
    parameter int NUM_REQ        = 2,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [16*NUM_REQ-1:0] req_cmd,
    output logic [NUM_REQ-1:0]    grant,
    output logic                  resp_valid,
    output logic [15:0]           resp_data,
    output logic                  resp_error,
    output logic                  tx_start,
    output logic [7:0]            tx_byte,
    input  logic                  tx_busy,
    input  logic                  tx_done,
    input  logic                  rx_valid,
    input  logic [7:0]            rx_byte
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IDX_W-1:0] LAST_INIT = IDX_W'(NUM_REQ - 1);
    localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        SEND_HI,
        WAIT_HI,
        SEND_LO,
        WAIT_LO,
        RECV_HI,
        RECV_LO,
        RESP
    } state_t;

    state_t             state;
    logic [IDX_W-1:0]   last_grant;
    logic [TMR_W-1:0]   timer;
    logic [7:0]         cmd_lo;
    logic [7:0]         rx_hi;
    logic               tx_done_q;
    logic               rx_valid_q;

    logic               win_found;
    logic [IDX_W-1:0]   win_idx;
    logic [NUM_REQ-1:0] win_onehot;
    logic [15:0]        win_cmd;
    int                 scan_idx;
    logic               tx_done_rise;
    logic               rx_rise;
    logic               exit_edge;

    // Round-robin search starting just after the previous winner, wrapping around.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        scan_idx  = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            scan_idx = (int'(last_grant) + k) % NUM_REQ;
            if (!win_found && req[scan_idx]) begin
                win_found = 1'b1;
                win_idx   = IDX_W'(scan_idx);
            end
        end
    end

    assign win_onehot = NUM_REQ'(1) << win_idx;
    assign win_cmd    = req_cmd[16*win_idx +: 16];

    // Previous-value registers reset to 1 so a level already high is never seen as an edge.
    assign tx_done_rise = tx_done & ~tx_done_q;
    assign rx_rise      = rx_valid & ~rx_valid_q;

    always_comb begin
        exit_edge = 1'b0;
        case (state)
            WAIT_HI, WAIT_LO: exit_edge = tx_done_rise;
            RECV_HI, RECV_LO: exit_edge = rx_rise;
            default:          exit_edge = 1'b0;
        endcase
    end

    // Fires in the first SEND cycle that the transmitter is free; the FSM leaves SEND on that edge.
    assign tx_start = ((state == SEND_HI) || (state == SEND_LO)) && !tx_busy;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state      <= IDLE;
            grant      <= '0;
            resp_valid <= 1'b0;
            resp_data  <= '0;
            resp_error <= 1'b0;
            tx_byte    <= '0;
            cmd_lo     <= '0;
            rx_hi      <= '0;
            last_grant <= LAST_INIT;
            timer      <= '0;
            tx_done_q  <= 1'b1;
            rx_valid_q <= 1'b1;
        end else begin
            tx_done_q  <= tx_done;
            rx_valid_q <= rx_valid;
            case (state)
                IDLE: begin
                    if (win_found) begin
                        grant      <= win_onehot;
                        last_grant <= win_idx;
                        tx_byte    <= win_cmd[15:8];
                        cmd_lo     <= win_cmd[7:0];
                        state      <= SEND_HI;
                    end
                end
                SEND_HI: begin
                    if (!tx_busy) begin
                        timer <= '0;
                        state <= WAIT_HI;
                    end
                end
                SEND_LO: begin
                    if (!tx_busy) begin
                        timer <= '0;
                        state <= WAIT_LO;
                    end
                end
                WAIT_HI, WAIT_LO, RECV_HI, RECV_LO: begin
                    if (exit_edge) begin
                        timer <= '0;
                        case (state)
                            WAIT_HI: begin
                                tx_byte <= cmd_lo;
                                state   <= SEND_LO;
                            end
                            WAIT_LO: state <= RECV_HI;
                            RECV_HI: begin
                                rx_hi <= rx_byte;
                                state <= RECV_LO;
                            end
                            default: begin
                                resp_data  <= {rx_hi, rx_byte};
                                resp_error <= 1'b0;
                                state      <= RESP;
                            end
                        endcase
                    end else if (timer == TMR_LAST) begin
                        // Abort straight into the pulse cycle of RESP.
                        resp_valid <= 1'b1;
                        resp_error <= 1'b1;
                        resp_data  <= '0;
                        state      <= RESP;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                RESP: begin
                    // First RESP cycle after a normal reply raises the pulse; the pulse cycle ends the transaction.
                    if (!resp_valid) begin
                        resp_valid <= 1'b1;
                    end else begin
                        resp_valid <= 1'b0;
                        grant      <= '0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sensor_command_scheduler.sv
// Randomized bench for sensor_command_scheduler with a queue-based round-robin reference model.
// Latency: inputs driven 1 time unit after the rising edge, outputs sampled 3 time units after it.
// Backpressure: bench plays the UART pair, stretching tx_busy, tx_done and rx_valid timing at random.
module tb_sensor_command_scheduler;

    localparam int NR = 2;
    localparam int TO = 16;

    logic            clock;
    logic            reset;
    logic [NR-1:0]   req;
    logic [16*NR-1:0] req_cmd;
    logic [NR-1:0]   grant;
    logic            resp_valid;
    logic [15:0]     resp_data;
    logic            resp_error;
    logic            tx_start;
    logic [7:0]      tx_byte;
    logic            tx_busy;
    logic            tx_done;
    logic            rx_valid;
    logic [7:0]      rx_byte;

    int errors = 0;
    int checks = 0;
    int prio_q[$];   // requesters in current priority order, most favoured first

    sensor_command_scheduler #(.NUM_REQ(NR), .TIMEOUT_CYCLES(TO)) dut (
        .clock      (clock),
        .reset      (reset),
        .req        (req),
        .req_cmd    (req_cmd),
        .grant      (grant),
        .resp_valid (resp_valid),
        .resp_data  (resp_data),
        .resp_error (resp_error),
        .tx_start   (tx_start),
        .tx_byte    (tx_byte),
        .tx_busy    (tx_busy),
        .tx_done    (tx_done),
        .rx_valid   (rx_valid),
        .rx_byte    (rx_byte)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic model_reset();
        prio_q.delete();
        for (int i = 0; i < NR; i++) prio_q.push_back(i);
    endtask

    // Winner is the most favoured requesting index; it then drops to least favoured.
    task automatic model_pick(input logic [NR-1:0] r, output int w);
        w = -1;
        foreach (prio_q[i]) if (w < 0 && r[prio_q[i]]) w = prio_q[i];
        if (w < 0) w = 0;
        while (prio_q[$] != w) begin
            int h;
            h = prio_q.pop_front();
            prio_q.push_back(h);
        end
    endtask

    task automatic wait_done(input int hold, input logic [7:0] exp_b);
        int d;
        d = $urandom_range(1, 4);
        for (int k = 0; k < hold + d; k++) begin
            tick();
            tx_done  = (k < hold);
            tx_busy  = 1'b1;
            rx_valid = (k == 0);   // stray receiver byte outside RECV
            rx_byte  = 8'hEE;
            settle();
            checks++;
            if (tx_start !== 1'b0 || tx_byte !== exp_b || resp_valid !== 1'b0) begin
                errors++;
                $display("FAIL wait_quiet: tx_start=%b tx_byte=%h resp_valid=%b, want 0 %h 0", tx_start, tx_byte, resp_valid, exp_b);
            end
        end
        tick();
        tx_done  = 1'b1;
        tx_busy  = 1'b0;
        rx_valid = 1'b0;
        settle();
    endtask

    task automatic recv_byte(input logic [7:0] v);
        int d;
        d = $urandom_range(1, 4);
        for (int k = 0; k < d; k++) begin
            tick();
            tx_done  = 1'b0;
            rx_valid = 1'b0;
            rx_byte  = 8'($urandom);
            settle();
            checks++;
            if (tx_start !== 1'b0 || resp_valid !== 1'b0) begin
                errors++;
                $display("FAIL recv_quiet: tx_start=%b resp_valid=%b, want 0 0", tx_start, resp_valid);
            end
        end
        tick();
        rx_valid = 1'b1;
        rx_byte  = v;
        settle();
    endtask

    // mode 0: normal reply, 1: no tx_done in WAIT_HI, 2: receiver sends only the first byte.
    // Entered in an IDLE cycle with req already driven.
    task automatic do_txn(input int mode, input int busy_cyc, input int done_hold,
                          input logic [7:0] b_hi, input logic [7:0] b_lo, input bit release_req);
        int          who;
        logic [15:0] cmd;
        logic [NR-1:0] g;
        logic [15:0] exp_data;
        logic        exp_err;
        model_pick(req, who);
        cmd = req_cmd[16*who +: 16];
        g = '0;
        g[who] = 1'b1;
        tx_busy = (busy_cyc > 0);
        tick();
        settle();
        checks++;
        if (grant !== g || tx_byte !== cmd[15:8]) begin
            errors++;
            $display("FAIL grant_hi: grant=%b tx_byte=%h, want %b %h", grant, tx_byte, g, cmd[15:8]);
        end
        for (int k = 0; k < busy_cyc; k++) begin
            checks++;
            if (tx_start !== 1'b0) begin
                errors++;
                $display("FAIL busy_hold: tx_start=%b at busy cycle %0d, want 0", tx_start, k);
            end
            tick();
            tx_busy = (k + 1 < busy_cyc);
            settle();
        end
        checks++;
        if (tx_start !== 1'b1 || tx_byte !== cmd[15:8]) begin
            errors++;
            $display("FAIL start_hi: tx_start=%b tx_byte=%h, want 1 %h", tx_start, tx_byte, cmd[15:8]);
        end
        if (mode == 1) begin
            for (int k = 0; k < TO; k++) begin
                tick();
                settle();
                checks++;
                if (tx_start !== 1'b0 || resp_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL wait_timeout_quiet: tx_start=%b resp_valid=%b at cycle %0d, want 0 0", tx_start, resp_valid, k);
                end
            end
            exp_data = 16'h0000;
            exp_err  = 1'b1;
        end else begin
            wait_done(done_hold, cmd[15:8]);
            tick();
            tx_done = 1'b0;
            settle();
            checks++;
            if (tx_start !== 1'b1 || tx_byte !== cmd[7:0]) begin
                errors++;
                $display("FAIL start_lo: tx_start=%b tx_byte=%h, want 1 %h", tx_start, tx_byte, cmd[7:0]);
            end
            wait_done(0, cmd[7:0]);
            recv_byte(b_hi);
            if (mode == 2) begin
                for (int k = 0; k < TO; k++) begin
                    tick();
                    rx_valid = 1'b0;
                    rx_byte  = 8'($urandom);
                    settle();
                    checks++;
                    if (resp_valid !== 1'b0) begin
                        errors++;
                        $display("FAIL rx_timeout_early: resp_valid=%b at cycle %0d of RECV_LO, want 0", resp_valid, k);
                    end
                end
                exp_data = 16'h0000;
                exp_err  = 1'b1;
            end else begin
                recv_byte(b_lo);
                tick();
                rx_valid = 1'b0;
                settle();
                checks++;
                if (resp_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL resp_lag: resp_valid=%b one cycle after last byte, want 0", resp_valid);
                end
                exp_data = {b_hi, b_lo};
                exp_err  = 1'b0;
            end
        end
        tick();
        rx_valid = 1'b0;
        settle();
        checks++;
        if (resp_valid !== 1'b1 || resp_data !== exp_data || resp_error !== exp_err || grant !== g) begin
            errors++;
            $display("FAIL resp: valid=%b data=%h err=%b grant=%b, want 1 %h %b %b",
                     resp_valid, resp_data, resp_error, grant, exp_data, exp_err, g);
        end
        if (release_req) req[who] = 1'b0;
        tick();
        settle();
        checks++;
        if (grant !== '0 || resp_valid !== 1'b0 || tx_start !== 1'b0) begin
            errors++;
            $display("FAIL release: grant=%b resp_valid=%b tx_start=%b, want 0 0 0", grant, resp_valid, tx_start);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        req = '0;
        req_cmd = '0;
        tx_busy = 1'b0;
        tx_done = 1'b0;
        rx_valid = 1'b0;
        rx_byte = '0;
        model_reset();
        tick();
        tick();
        tick();
        settle();
        checks++;
        if ({grant, resp_valid, resp_data, resp_error, tx_start, tx_byte} !== '0) begin
            errors++;
            $display("FAIL reset_state: grant=%b rv=%b rd=%h re=%b ts=%b tb=%h, want all 0",
                     grant, resp_valid, resp_data, resp_error, tx_start, tx_byte);
        end
        reset = 1'b1;
        tick();
        settle();
        checks++;
        if ({grant, resp_valid, tx_start} !== '0) begin
            errors++;
            $display("FAIL reset_idle: grant=%b resp_valid=%b tx_start=%b, want 0 0 0", grant, resp_valid, tx_start);
        end
    endtask

    task automatic test_single();
        req_cmd[15:0] = 16'h4F21;
        req = 2'b01;
        do_txn(0, 0, 0, 8'hA5, 8'h3C, 1'b1);
        tick();
        settle();
        checks++;
        if (grant !== '0) begin
            errors++;
            $display("FAIL single_idle: grant=%b with no request, want 00", grant);
        end
    endtask

    task automatic test_round_robin();
        req_cmd = 32'($urandom);
        req = 2'b11;
        for (int t = 0; t < 4; t++)
            do_txn(0, $urandom_range(0, 2), 0, 8'($urandom), 8'($urandom), 1'b0);
        req = '0;
        tick();
        settle();
        checks++;
        if (grant !== '0) begin
            errors++;
            $display("FAIL rr_idle: grant=%b after requests dropped, want 00", grant);
        end
    endtask

    task automatic test_tx_busy();
        req_cmd[15:0] = 16'($urandom);
        req = 2'b01;
        do_txn(0, 20, 0, 8'($urandom), 8'($urandom), 1'b1);
    endtask

    task automatic test_rx_timeout();
        req_cmd[31:16] = 16'($urandom);
        req = 2'b10;
        do_txn(2, 0, 0, 8'($urandom), 8'h00, 1'b1);
    endtask

    task automatic test_wait_timeout();
        req_cmd[15:0] = 16'($urandom);
        req = 2'b01;
        do_txn(1, 1, 0, 8'h00, 8'h00, 1'b1);
    endtask

    task automatic test_stray();
        req = '0;
        tick();
        rx_valid = 1'b1;
        rx_byte  = 8'h77;
        settle();
        tick();
        rx_valid = 1'b0;
        settle();
        checks++;
        if ({grant, resp_valid, tx_start} !== '0) begin
            errors++;
            $display("FAIL stray_idle: grant=%b resp_valid=%b tx_start=%b, want 0 0 0", grant, resp_valid, tx_start);
        end
        tx_done = 1'b1;
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        model_reset();
        settle();
        req = 2'b01;
        req_cmd[15:0] = 16'($urandom);
        do_txn(0, 0, 3, 8'($urandom), 8'($urandom), 1'b1);
    endtask

    task automatic test_reset_mid();
        int w;
        req_cmd[31:16] = 16'($urandom);
        req = 2'b10;
        tx_busy = 1'b0;
        tx_done = 1'b0;
        model_pick(req, w);
        tick();
        settle();
        checks++;
        if (grant !== 2'b10 || tx_start !== 1'b1) begin
            errors++;
            $display("FAIL mid_grant: grant=%b tx_start=%b, want 10 1", grant, tx_start);
        end
        tick();
        settle();
        tick();
        tx_done = 1'b1;
        settle();
        tick();
        tx_done = 1'b0;
        settle();
        checks++;
        if (tx_start !== 1'b1 || tx_byte !== req_cmd[23:16]) begin
            errors++;
            $display("FAIL mid_start_lo: tx_start=%b tx_byte=%h, want 1 %h", tx_start, tx_byte, req_cmd[23:16]);
        end
        tick();
        settle();
        tick();
        reset = 1'b0;
        settle();
        tick();
        reset = 1'b1;
        req = '0;
        model_reset();
        settle();
        checks++;
        if ({grant, tx_start, resp_valid} !== '0) begin
            errors++;
            $display("FAIL mid_reset: grant=%b tx_start=%b resp_valid=%b, want 0 0 0", grant, tx_start, resp_valid);
        end
        req = 2'b01;
        req_cmd[15:0] = 16'($urandom);
        do_txn(0, 0, 0, 8'($urandom), 8'($urandom), 1'b1);
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_tx_busy();
        test_rx_timeout();
        test_wait_timeout();
        test_stray();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
